fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of `icache`. Holds the fetch PC and presents it to the instruction cache as `proc2Icache_addr`. On a cache hit it extracts one or two 32-bit instructions from the 64-bit line and pushes them into an internal instruction queue. The queue drains one instruction per cycle to decode and is flushed on a control-flow redirect.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/inst_queue.sv | 63 ++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// XLEN matches the core datapath; iq_entry_t is one queued instruction with its PC.
package fetch_unit_pkg;

  localparam int XLEN             = 32;
  localparam int IQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } iq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO: 0-2 pushes and 0-1 pop per cycle, synchronous flush.
// Head entry is read combinationally; the caller guarantees push_cnt_i never exceeds free space.
module inst_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [1:0]               push_cnt_i,
  input  iq_entry_t                push0_dat_i,
  input  iq_entry_t                push1_dat_i,
  input  logic                     pop_i,
  output iq_entry_t                head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  iq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     tail_p1;
  logic [PW:0]       count_q, count_d;
  logic              wr_en;

  // Pointers are exactly log2(DEPTH) bits, so +1 wraps for free.
  assign tail_p1 = tail_q + PW'(1);
  assign wr_en   = !rst_i && !flush_i;

  always_comb begin
    head_d  = head_q + PW'(pop_i);
    tail_d  = tail_q + PW'(push_cnt_i);
    count_d = count_q + (PW+1)'(push_cnt_i) - (PW+1)'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A 2-wide push at tail = DEPTH-1 lands in the last slot and slot 0.
  always_ff @(posedge clk_i) begin
    if (wr_en && (push_cnt_i != 2'd0)) begin
      mem_q[tail_q] <= push0_dat_i;
    end
    if (wr_en && (push_cnt_i == 2'd2)) begin
      mem_q[tail_p1] <= push1_dat_i;
    end
  end

  assign head_dat_o = mem_q[head_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: holds the PC, splits 64-bit icache lines into 1-2 instructions, queues them for decode.
// Hit-to-decode latency 1 cycle; fetch stalls with PC held on a miss or a full queue; redirect flushes.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              IQ_DEPTH = IQ_DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [63:0]                 Icache_data_out,
  input  logic                        Icache_valid_out,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        dec_ready,
  output logic [XLEN-1:0]             proc2Icache_addr,
  output logic                        if_valid,
  output logic [31:0]                 if_inst,
  output logic [XLEN-1:0]             if_pc,
  output logic [XLEN-1:0]             if_npc,
  output logic [$clog2(IQ_DEPTH):0]   iq_count
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   free;
  logic [1:0]      push_cnt;
  iq_entry_t       push0_dat, push1_dat, head_dat;
  logic            pop;
  logic [1:0]      unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Free space uses the registered count only; a same-cycle pop never makes room.
  assign free = CW'(IQ_DEPTH) - iq_count;

  always_comb begin
    push_cnt       = 2'd0;
    push0_dat.inst = Icache_data_out[31:0];
    push0_dat.pc   = pc_q;
    push1_dat.inst = Icache_data_out[63:32];
    push1_dat.pc   = pc_q + XLEN'(4);
    if (Icache_valid_out && !redirect_valid) begin
      if (!pc_q[2]) begin
        if (free >= CW'(2)) begin
          push_cnt = 2'd2;
        end else if (free == CW'(1)) begin
          push_cnt = 2'd1;
        end
      end else begin
        push0_dat.inst = Icache_data_out[63:32];
        if (free != '0) begin
          push_cnt = 2'd1;
        end
      end
    end
  end

  always_comb begin
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end else begin
      pc_d = pc_q + XLEN'({push_cnt, 2'b00});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign if_valid = (iq_count != '0) && !redirect_valid;
  assign pop      = if_valid && dec_ready;

  inst_queue #(
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk_i       (clock),
    .rst_i       (reset),
    .flush_i     (redirect_valid),
    .push_cnt_i  (push_cnt),
    .push0_dat_i (push0_dat),
    .push1_dat_i (push1_dat),
    .pop_i       (pop),
    .head_dat_o  (head_dat),
    .count_o     (iq_count)
  );

  assign proc2Icache_addr = pc_q;
  assign if_inst          = head_dat.inst;
  assign if_pc            = head_dat.pc;
  assign if_npc           = head_dat.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: icache model returns an address-derived word per slot,
// and every decoded instruction is checked against a running expected-PC stream.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic [31:0] proc2Icache_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic [3:0]  iq_count;

  logic        hit;
  logic [31:0] exp_pc;
  int          checks;
  int          failures;

  fetch_unit #(
    .IQ_DEPTH (8),
    .RESET_PC (32'h0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_ready        (dec_ready),
    .proc2Icache_addr (proc2Icache_addr),
    .if_valid         (if_valid),
    .if_inst          (if_inst),
    .if_pc            (if_pc),
    .if_npc           (if_npc),
    .iq_count         (iq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  assign Icache_valid_out = hit;
  assign Icache_data_out  = {inst_of({proc2Icache_addr[31:3], 3'b100}),
                             inst_of({proc2Icache_addr[31:3], 3'b000})};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, sample mid-cycle, track the decode stream.
  task automatic cyc(input logic r, input logic h, input logic rv,
                     input logic [31:0] rpc, input logic dr);
    @(posedge clock);
    #1;
    reset          = r;
    hit            = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = dr;
    #3;
    if (r) begin
      exp_pc = 32'h0;
    end else if (rv) begin
      check("redirect_if_valid", 32'(if_valid), 32'd0);
      exp_pc = {rpc[31:2], 2'b00};
    end else if (if_valid && dec_ready) begin
      check("stream_pc", if_pc, exp_pc);
      check("stream_inst", if_inst, inst_of(exp_pc));
      check("stream_npc", if_npc, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    exp_pc         = 32'h0;
    reset          = 1'b1;
    hit            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;

    // Reset state
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    check("rst_addr", proc2Icache_addr, 32'h0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_count", 32'(iq_count), 32'd0);

    // Sequential fetch, always hit, decode always ready
    cyc(0, 1, 0, 32'h0, 1);
    check("seq_addr0", proc2Icache_addr, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      cyc(0, 1, 0, 32'h0, 1);
      check("seq_valid", 32'(if_valid), 32'd1);
      if (c <= 6) begin
        check("seq_addr", proc2Icache_addr, 32'(8 * c));
        check("seq_count", 32'(iq_count), 32'(c + 1));
      end
    end

    // Odd-word start
    cyc(0, 0, 1, 32'h0000_0104, 1);
    cyc(0, 1, 0, 32'h0, 1);
    check("odd_addr", proc2Icache_addr, 32'h104);
    check("odd_count0", 32'(iq_count), 32'd0);
    check("odd_valid0", 32'(if_valid), 32'd0);
    cyc(0, 0, 0, 32'h0, 0);
    check("odd_valid1", 32'(if_valid), 32'd1);
    check("odd_pc", if_pc, 32'h104);
    check("odd_inst", if_inst, inst_of(32'h104));
    check("odd_count1", 32'(iq_count), 32'd1);
    check("odd_next_addr", proc2Icache_addr, 32'h108);

    // Miss stall at 0x40 with four entries queued
    cyc(0, 0, 1, 32'h30, 0);
    cyc(0, 1, 0, 32'h0, 0);
    check("miss_pre_addr0", proc2Icache_addr, 32'h30);
    cyc(0, 1, 0, 32'h0, 0);
    check("miss_pre_addr1", proc2Icache_addr, 32'h38);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 32'h0, 1);
      check("miss_addr_hold", proc2Icache_addr, 32'h40);
      check("miss_count", 32'(iq_count), 32'(4 - i));
    end
    cyc(0, 1, 0, 32'h0, 0);
    check("miss_hit_addr", proc2Icache_addr, 32'h40);
    cyc(0, 0, 0, 32'h0, 1);
    check("miss_after_count", 32'(iq_count), 32'd2);
    check("miss_after_pc", if_pc, 32'h40);
    cyc(0, 0, 0, 32'h0, 1);
    check("miss_after_pc2", if_pc, 32'h44);

    // Full queue, free=1 pushes, and a 2-wide push straddling the wrap
    cyc(0, 0, 1, 32'h2FC, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 32'h0, 0);
      check("full_count", 32'(iq_count), 32'd8);
      check("full_addr_hold", proc2Icache_addr, 32'h31C);
    end
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 1, 0, 32'h0, 0);
    check("free1_hi_count", 32'(iq_count), 32'd7);
    check("free1_hi_addr", proc2Icache_addr, 32'h31C);
    cyc(0, 0, 0, 32'h0, 1);
    check("free1_hi_after", proc2Icache_addr, 32'h320);
    check("free1_hi_cnt8", 32'(iq_count), 32'd8);
    cyc(0, 1, 0, 32'h0, 0);
    check("free1_lo_count", 32'(iq_count), 32'd7);
    cyc(0, 0, 0, 32'h0, 0);
    check("free1_lo_addr", proc2Icache_addr, 32'h324);
    check("free1_lo_cnt8", 32'(iq_count), 32'd8);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 0);
    check("wrap_count", 32'(iq_count), 32'd7);

    // Redirect together with a hit and a ready decoder at count 5
    cyc(0, 0, 1, 32'h500, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 1, 1, 32'h203, 1);
    check("redir_count_before", 32'(iq_count), 32'd5);
    cyc(0, 1, 0, 32'h0, 1);
    check("redir_count_after", 32'(iq_count), 32'd0);
    check("redir_addr", proc2Icache_addr, 32'h200);
    check("redir_valid_after", 32'(if_valid), 32'd0);
    cyc(0, 0, 0, 32'h0, 1);
    check("redir_first_valid", 32'(if_valid), 32'd1);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    check("redir_drained_valid", 32'(if_valid), 32'd0);
    check("redir_drained_count", 32'(iq_count), 32'd0);

    // Reset mid-stream with six entries queued
    cyc(0, 0, 1, 32'h600, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h0, 0);
    cyc(1, 1, 0, 32'h0, 1);
    check("mrst_count_before", 32'(iq_count), 32'd6);
    cyc(0, 0, 0, 32'h0, 1);
    check("mrst_valid", 32'(if_valid), 32'd0);
    check("mrst_count", 32'(iq_count), 32'd0);
    check("mrst_addr", proc2Icache_addr, 32'h0);
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    check("mrst_first_valid", 32'(if_valid), 32'd1);
    cyc(0, 0, 0, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
